// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS memory-port arbiter: FSM state and grant
// encodings, default bus widths, the timeout fill pattern and the arbitration
// helper used by mem_port_arbiter.
package mips_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  // Pattern returned to a requester whose access was aborted by the timeout.
  localparam logic [31:0] DEAD_BEEF = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_DM = 1'b1
  } grant_e;

  // Data side wins a tie unless it also won the previous access, so a
  // back-to-back load/store stream cannot lock fetch out.
  function automatic grant_e pick_grant(input logic if_req,
                                        input logic dm_req,
                                        input grant_e last_grant);
    if (dm_req && if_req) begin
      return (last_grant == GNT_DM) ? GNT_IF : GNT_DM;
    end else if (dm_req) begin
      return GNT_DM;
    end else begin
      return GNT_IF;
    end
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-port, variable-latency memory between instruction fetch
// (IF) and data memory (DM). One access is in flight at a time; each access
// runs IDLE -> BUSY -> RESP, and the waiting stage sees its stall asserted
// until its one-cycle valid pulse.
//
// Optional build macro MEM_ARB_TIMEOUT_EN: adds the TIMEOUT_CYC parameter and
// the arb_err output. A BUSY phase lasting TIMEOUT_CYC cycles without mem_ack
// is aborted and the requester receives DEAD_BEEF with arb_err set.
module mem_port_arbiter
  import mips_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
`ifdef MEM_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 255
`endif
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,

  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              dm_stall,

  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
`ifdef MEM_ARB_TIMEOUT_EN
  ,
  output logic              arb_err
`endif
);

  arb_state_e state;
  grant_e     grant;
  grant_e     last_grant;
  grant_e     next_grant;

  assign next_grant = pick_grant(if_req, dm_req, last_grant);

  // NOTE: stalls are plain continuous assigns of registered valids, so they
  // are combinational by construction and can never infer a latch.
  assign if_stall = if_req & ~if_valid;
  assign dm_stall = dm_req & ~dm_valid;

`ifdef MEM_ARB_TIMEOUT_EN
  // Counter holds the number of completed BUSY cycles; it is wide enough to
  // hold TIMEOUT_CYC so any legal parameter value fits.
  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

  logic [TO_W-1:0] to_cnt;
  logic            to_hit;

  assign to_hit = (state == BUSY) && (to_cnt == TO_W'(TIMEOUT_CYC - 1));
`endif

  // Arbitration FSM with all memory-side and requester-side outputs registered.
  // NOTE: every assignment here is non-blocking so all registers update
  // together at the edge; reset is synchronous and clears every register
  // because there is no storage array that could be left uninitialised.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= GNT_IF;
      last_grant <= GNT_IF;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_valid   <= 1'b0;
      dm_valid   <= 1'b0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      to_cnt     <= '0;
      arb_err    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (if_req || dm_req) begin
            grant   <= next_grant;
            mem_req <= 1'b1;
            if (next_grant == GNT_DM) begin
              mem_we    <= dm_we;
              mem_addr  <= dm_addr;
              mem_wdata <= dm_wdata;
            end else begin
              mem_we    <= 1'b0;
              mem_addr  <= if_addr;
              mem_wdata <= '0;
            end
`ifdef MEM_ARB_TIMEOUT_EN
            to_cnt <= '0;
`endif
            state <= BUSY;
          end
        end

        BUSY: begin
          // mem_* stay untouched here, so the memory sees a stable request.
          if (mem_ack) begin
            mem_req    <= 1'b0;
            last_grant <= grant;
            state      <= RESP;
            if (grant == GNT_DM) begin
              dm_rdata <= mem_rdata;
              dm_valid <= 1'b1;
            end else begin
              if_rdata <= mem_rdata;
              if_valid <= 1'b1;
            end
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else if (to_hit) begin
            mem_req    <= 1'b0;
            last_grant <= grant;
            arb_err    <= 1'b1;
            state      <= RESP;
            if (grant == GNT_DM) begin
              dm_rdata <= DATA_W'(DEAD_BEEF);
              dm_valid <= 1'b1;
            end else begin
              if_rdata <= DATA_W'(DEAD_BEEF);
              if_valid <= 1'b1;
            end
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end

        RESP: begin
          if_valid <= 1'b0;
          dm_valid <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
          arb_err  <= 1'b0;
`endif
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. The stimulus process drives the
// requesters and plays the memory; completions are predicted into a queue and
// a monitor process checks every valid pulse against the queue head.
// Define MEM_ARB_TIMEOUT_EN to also exercise the timeout path (TIMEOUT_CYC=4).
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        if_stall;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_valid;
  logic        dm_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
`ifdef MEM_ARB_TIMEOUT_EN
  logic        arb_err;
`endif

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(32),
    .DATA_W(32)
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    .TIMEOUT_CYC(4)
`endif
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_valid (if_valid),
    .if_stall (if_stall),
    .dm_req   (dm_req),
    .dm_we    (dm_we),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_rdata (dm_rdata),
    .dm_valid (dm_valid),
    .dm_stall (dm_stall),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack)
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    .arb_err  (arb_err)
`endif
  );

  typedef struct {
    bit          is_dm;
    logic [31:0] data;
    bit          chk_data;
    bit          err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input bit is_dm, input logic [31:0] data,
                      input bit chk_data, input bit err);
    exp_t e;
    e.is_dm    = is_dm;
    e.data     = data;
    e.chk_data = chk_data;
    e.err      = err;
    exp_q.push_back(e);
  endtask

  // Monitor: every completion pulse must match the oldest prediction.
  always @(negedge clk) begin
    if (if_valid || dm_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: if_valid=%b dm_valid=%b with no pending access (t=%0t)",
                 if_valid, dm_valid, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("valid_both", {31'd0, if_valid & dm_valid}, 32'd0);
        check("valid_owner_dm", {31'd0, dm_valid}, {31'd0, e.is_dm});
        if (e.chk_data)
          check("rdata", e.is_dm ? dm_rdata : if_rdata, e.data);
`ifdef MEM_ARB_TIMEOUT_EN
        check("arb_err", {31'd0, arb_err}, {31'd0, e.err});
`endif
      end
    end
  end

  // Bounded wait for the arbiter to issue a memory request.
  task automatic wait_mem_req(output bit ok);
    int n;
    n = 0;
    while (!mem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = mem_req;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_mem_req: got mem_req=0 expected 1 within 20 cycles (t=%0t)", $time);
    end
  endtask

  // Plays the memory for one access: checks the request is held stable for
  // 'busy' cycles, acks on the last one when 'ack' is set, and returns at the
  // negedge of the RESP cycle. other: 1 = IF must stall, 2 = DM must stall.
  task automatic serve(input bit dm, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input int busy, input bit ack,
                       input logic [31:0] rdata, input int other);
    bit ok;
    wait_mem_req(ok);
    if (!ok) return;
    for (int i = 1; i <= busy; i++) begin
      check("busy_mem_req", {31'd0, mem_req}, 32'd1);
      check("busy_mem_we", {31'd0, mem_we}, {31'd0, we});
      check("busy_mem_addr", mem_addr, addr);
      if (we) check("busy_mem_wdata", mem_wdata, wdata);
      check("busy_own_stall", {31'd0, dm ? dm_stall : if_stall}, 32'd1);
      if (other == 1) check("busy_if_stall", {31'd0, if_stall}, 32'd1);
      if (other == 2) check("busy_dm_stall", {31'd0, dm_stall}, 32'd1);
      if (ack && i == busy) begin
        mem_ack   = 1'b1;
        mem_rdata = rdata;
      end
      @(negedge clk);
    end
    mem_ack = 1'b0;
    check("resp_mem_req", {31'd0, mem_req}, 32'd0);
    check("resp_own_stall", {31'd0, dm ? dm_stall : if_stall}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit          ok;
    bit          dm;
    logic [31:0] d;

    rst = 1'b1; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
    dm_addr = '0; dm_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);

    // Reset state.
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_if_valid", {31'd0, if_valid}, 32'd0);
    check("rst_dm_valid", {31'd0, dm_valid}, 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_dm_rdata", dm_rdata, 32'd0);

    // Single fetch with the fastest possible ack: exact latency.
    rst = 1'b0; if_req = 1'b1; if_addr = 32'h0000_0040;
    push(1'b0, 32'h2002_0005, 1'b1, 1'b0);
    @(negedge clk);
    check("t1_mem_req_n1", {31'd0, mem_req}, 32'd1);
    check("t1_mem_addr", mem_addr, 32'h0000_0040);
    check("t1_mem_we", {31'd0, mem_we}, 32'd0);
    check("t1_if_stall_busy", {31'd0, if_stall}, 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'h2002_0005;
    @(negedge clk);
    mem_ack = 1'b0;
    check("t1_mem_req_resp", {31'd0, mem_req}, 32'd0);
    check("t1_if_valid_n2", {31'd0, if_valid}, 32'd1);
    check("t1_if_stall_resp", {31'd0, if_stall}, 32'd0);
    if_req = 1'b0;
    @(negedge clk);
    check("t1_if_valid_drop", {31'd0, if_valid}, 32'd0);
    check("t1_if_rdata_hold", if_rdata, 32'h2002_0005);

    // Alternation: both requesters after reset, DM first, then IF, DM, ...
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    if_req = 1'b1; if_addr = 32'h0000_0100;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0200; dm_wdata = 32'h0;
    for (int k = 0; k < 7; k++) begin
      dm = (k % 2 == 0);
      d  = 32'hA000_0000 + 32'(k);
      push(dm, d, 1'b1, 1'b0);
      serve(dm, 1'b0, dm ? 32'h0000_0200 : 32'h0000_0100, 32'h0, 1 + (k % 3),
            1'b1, d, (k == 6) ? 0 : (dm ? 1 : 2));
      if (k == 5) if_req = 1'b0;
      if (k == 6) dm_req = 1'b0;
    end
    @(negedge clk);

    // Store with a slow memory while fetch waits; then fetch goes next.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h0000_0010; dm_wdata = 32'hCAFE_F00D;
    if_req = 1'b1; if_addr = 32'h0000_0044;
    push(1'b1, 32'h0, 1'b0, 1'b0);
    push(1'b0, 32'h0C0F_FEE0, 1'b1, 1'b0);
    serve(1'b1, 1'b1, 32'h0000_0010, 32'hCAFE_F00D, 5, 1'b1, 32'h1111_1111, 1);
    check("t3_if_stall_resp", {31'd0, if_stall}, 32'd1);
    dm_req = 1'b0; dm_we = 1'b0;
    serve(1'b0, 1'b0, 32'h0000_0044, 32'h0, 2, 1'b1, 32'h0C0F_FEE0, 0);
    if_req = 1'b0;
    @(negedge clk);

    // Reset in the middle of an access; a late ack must be ignored.
    if_req = 1'b1; if_addr = 32'h0000_0080;
    wait_mem_req(ok);
    rst = 1'b1; if_req = 1'b0;
    @(negedge clk);
    check("t4_rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("t4_rst_mem_addr", mem_addr, 32'd0);
    check("t4_rst_if_rdata", if_rdata, 32'd0);
    rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    repeat (2) begin
      @(negedge clk);
      check("t4_ack_ignored_req", {31'd0, mem_req}, 32'd0);
      check("t4_ack_ignored_valid", {31'd0, if_valid}, 32'd0);
    end
    mem_ack = 1'b0;
    check("t4_if_rdata_kept", if_rdata, 32'd0);
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0024;
    push(1'b1, 32'h1234_5678, 1'b1, 1'b0);
    serve(1'b1, 1'b0, 32'h0000_0024, 32'h0, 1, 1'b1, 32'h1234_5678, 0);
    dm_req = 1'b0;
    @(negedge clk);

`ifdef MEM_ARB_TIMEOUT_EN
    // No ack at all: aborted after 4 BUSY cycles with the error pattern.
    if_req = 1'b1; if_addr = 32'h0000_0300;
    push(1'b0, 32'hDEAD_BEEF, 1'b1, 1'b1);
    serve(1'b0, 1'b0, 32'h0000_0300, 32'h0, 4, 1'b0, 32'h0, 0);
    if_req = 1'b0;
    @(negedge clk);
    // Ack on the very cycle the timeout would fire: normal completion.
    if_req = 1'b1;
    push(1'b0, 32'h5555_AAAA, 1'b1, 1'b0);
    serve(1'b0, 1'b0, 32'h0000_0300, 32'h0, 4, 1'b1, 32'h5555_AAAA, 0);
    if_req = 1'b0;
    @(negedge clk);
`endif

    repeat (2) @(negedge clk);
    check("pending_predictions", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, variable-latency memory between the instruction-fetch stage and the data-memory stage of the 5-stage MIPS pipeline.
- Handshake: req/ack toward memory; req/valid toward each requester.
- Generates per-requester stall signals, so the pipeline freezes the stage that is waiting.
- Arbitration: data side has priority, with anti-starvation alternation so fetch cannot be locked out.

Parameters:
- ADDR_W, 32, address width of all address ports.
- DATA_W, 32, data width of all data ports.
- TIMEOUT_CYC, 255, BUSY-cycle limit. Used only when MEM_ARB_TIMEOUT_EN is defined.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held high with if_addr stable until if_valid.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetched word; registered; valid while if_valid=1.
- if_valid  out  1  one-cycle completion pulse for fetch.
- if_stall  out  1  if_req & ~if_valid (combinational).
- dm_req  in  1  data request; held high with dm_we/dm_addr/dm_wdata stable until dm_valid.
- dm_we  in  1  1 = write, 0 = read.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_rdata  out  DATA_W  load data; registered; valid while dm_valid=1.
- dm_valid  out  1  one-cycle completion pulse for data.
- dm_stall  out  1  dm_req & ~dm_valid (combinational).
- mem_req  out  1  registered request to memory.
- mem_we  out  1  registered write enable to memory.
- mem_addr  out  ADDR_W  registered memory address.
- mem_wdata  out  DATA_W  registered memory write data.
- mem_rdata  in  DATA_W  memory read data; sampled when mem_ack=1.
- mem_ack  in  1  memory completion; valid only while mem_req=1.

Behaviour:
- FSM states: IDLE, BUSY, RESP. Registers: grant (0 = IF, 1 = DM) and last_grant.
- IDLE:
  - If dm_req=1 and if_req=1: grant DM, unless last_grant=DM, in which case grant IF (alternation).
  - Otherwise grant whichever requester is active.
  - On a grant, latch the grantee's we/addr/wdata into mem_* (mem_we=0 for IF), set mem_req=1, go to BUSY.
  - No request: stay in IDLE.
- BUSY:
  - mem_* outputs are held constant.
  - When mem_ack=1 at a clock edge:
    - mem_req goes to 0.
    - mem_rdata is captured into the grantee's rdata register; the captured value is don't-care for writes.
    - last_grant is updated to grant.
    - Go to RESP.
- RESP: exactly one cycle.
  - The grantee's valid is 1; no arbitration takes place.
  - The requester may drop its req or change its fields during this cycle.
  - Next state is IDLE.
- Latency:
  - req seen at edge N gives mem_req=1 in cycle N+1.
  - With mem_ack in cycle N+1, valid=1 in cycle N+2.
  - Minimum occupancy: 3 cycles per access.
- Only one access is in flight at a time. mem_ack outside BUSY is ignored.
- The non-granted requester keeps its stall asserted throughout.
- rdata registers hold their last captured value between accesses.
- Reset, including mid-access:
  - state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - if_valid=0, dm_valid=0, if_rdata=0, dm_rdata=0, last_grant=IF.
  - An abandoned memory transaction is dropped. Memory must accept mem_req falling without an ack.
- Simultaneous dm_req and if_req rising in the same cycle after reset: DM wins, because last_grant=IF.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- With the macro defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle.
  - When the counter reaches TIMEOUT_CYC with no mem_ack, the access is aborted: mem_req=0, go to RESP.
  - The grantee's rdata is loaded with 32'hDEAD_BEEF, and the extra output arb_err (1 bit, reset 0) pulses with valid.
  - mem_ack arriving on the same edge as the timeout wins: a normal completion, no error.
- Without the macro: no counter and no arb_err port; BUSY waits indefinitely.

Decomposition:
- Shared package mips_pkg holds:
  - FSM state encoding: IDLE=2'd0, BUSY=2'd1, RESP=2'd2.
  - Grant encoding: GNT_IF=1'b0, GNT_DM=1'b1.
  - ADDR_W/DATA_W defaults.
  - The DEAD_BEEF constant.
- No sub-module is required.
- The timeout counter may be split out as arb_timeout_cnt (clk, rst, clr, en, hit) when the macro is enabled.

Test Plan:
- Reset release, if_req=1, if_addr=0x0000_0040, mem_ack asserted the first cycle mem_req is seen, mem_rdata=0x2002_0005 -> mem_req high 1 cycle after req, if_valid pulse 2 cycles after req, if_rdata=0x2002_0005, if_stall low only during the valid cycle.
- dm_req and if_req asserted together from IDLE after reset -> DM granted first, IF granted next, DM granted after that if still requesting (alternation verified over 6 accesses).
- dm store dm_we=1, dm_addr=0x10, dm_wdata=0xCAFE_F00D, mem_ack after 5 BUSY cycles -> mem_we=1 with stable addr/data for all 5 cycles, dm_valid after ack, if_stall held high throughout.
- rst asserted during BUSY, then mem_ack arrives -> mem_req=0 the cycle after rst, no valid pulse, ack ignored, first post-reset request serviced normally.
- MEM_ARB_TIMEOUT_EN defined, TIMEOUT_CYC=4, mem_ack never asserted -> abort after 4 BUSY cycles, rdata=0xDEAD_BEEF, arb_err and valid pulse together; repeat with ack on cycle 4 -> normal data, arb_err=0.
